multi_cycle_controller: RTL and testbench

MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

---
 rtl/multi_cycle_controller_pkg.sv | 71 +++++++
 rtl/multi_cycle_controller_cond_check.sv | 36 +++
 rtl/multi_cycle_controller.sv | 159 +++++++++++++++
 tb/tb_multi_cycle_controller.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/multi_cycle_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multi_cycle_controller_pkg
// Purpose  : Shared types and tables for the multi-cycle controller: FSM
//            state encoding, instruction class codes, DP cmd -> ALUControl
//            mapping and branch condition codes.
// Revision : 1.0  initial release
// ============================================================================
package multi_cycle_controller_pkg;

  // FSM states; the numeric encoding is visible on state_o for debug
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  // Instruction class, Instr[15:14]
  localparam logic [1:0] CLASS_DPREG  = 2'b00;
  localparam logic [1:0] CLASS_DPIMM  = 2'b01;
  localparam logic [1:0] CLASS_MEM    = 2'b10;
  localparam logic [1:0] CLASS_BRANCH = 2'b11;

  // CMP only updates flags, so ALUWB must not write the register file
  localparam logic [2:0] CMD_CMP = 3'b100;

  // ALU operation codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_ORR = 4'b1100;
  localparam logic [3:0] ALU_MOV = 4'b1101;
  localparam logic [3:0] ALU_EOR = 4'b0001;
  localparam logic [3:0] ALU_BIC = 4'b1110;

  // Branch condition codes, Instr[11:8]; unlisted codes are never taken
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_AL = 4'b1110;

  // DP cmd (Instr[13:11]) to ALUControl; CMP reuses the SUB operation
  function automatic logic [3:0] alu_ctrl(input logic [2:0] cmd);
    logic [3:0] ctl;
    case (cmd)
      3'b000:  ctl = ALU_AND;
      3'b001:  ctl = ALU_SUB;
      3'b010:  ctl = ALU_ADD;
      3'b011:  ctl = ALU_ORR;
      3'b100:  ctl = ALU_SUB;
      3'b101:  ctl = ALU_MOV;
      3'b110:  ctl = ALU_EOR;
      default: ctl = ALU_BIC;
    endcase
    return ctl;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multi_cycle_controller_cond_check.sv
`default_nettype none
// ============================================================================
// Module   : cond_check
// Purpose  : Evaluates a 4-bit branch condition against stored {N,Z,C,V}.
// Revision : 1.0  initial release
// ============================================================================
module cond_check
  import multi_cycle_controller_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       CondEx
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  // Condition decode; any code not in the table evaluates false
  always_comb begin
    CondEx = 1'b0;
    case (cond)
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_AL: CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multi_cycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multi_cycle_controller
// Purpose  : Moore FSM sequencing a multi-cycle datapath through fetch,
//            decode, memory, data-processing and branch steps.
// Revision : 1.0  initial release
// ============================================================================
module multi_cycle_controller
  import multi_cycle_controller_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        ImmSrc,
  output logic        ALUSrcA,
  output logic [1:0]  AdrSrc,
  output logic [1:0]  ALUSrcB,
  output logic [3:0]  ALUControl,
  output logic [2:0]  RegSrc,
  output logic [1:0]  ResultSrc,
  output logic [3:0]  state_o
);

  state_t     state, state_next;
  logic [3:0] flags;
  logic       cond_ex;

  // Raw enables before reset gating
  logic pc_we, mem_we, ir_we, reg_we;

  logic [1:0] iclass;
  logic [2:0] cmd;
  logic       is_load_or_link;
  logic [3:0] cond;

  assign iclass          = Instr[15:14];
  assign is_load_or_link = Instr[13];
  assign cmd             = Instr[13:11];
  assign cond            = Instr[11:8];

  // Low instruction bits carry operands/immediates for the datapath only
  logic unused_instr_bits;
  assign unused_instr_bits = ^Instr[7:0];

  cond_check u_cond_check (
    .cond   (cond),
    .flags  (flags),
    .CondEx (cond_ex)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  // Flag register captures ALU flags only on the EXEC -> ALUWB edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                flags <= 4'b0000;
    else if (state == EXECR || state == EXECI) flags <= ALUFlags;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_next = FETCH;
    pc_we      = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    ImmSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    AdrSrc     = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = 4'b0000;
    RegSrc     = 3'b000;
    ResultSrc  = 2'b00;
    case (state)
      FETCH: begin
        ir_we      = 1'b1;
        pc_we      = 1'b1;
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUControl = ALU_ADD;
        ResultSrc  = 2'b10;
        state_next = DECODE;
      end
      DECODE: begin
        case (iclass)
          CLASS_DPREG: state_next = EXECR;
          CLASS_DPIMM: state_next = EXECI;
          CLASS_MEM:   state_next = MEMADR;
          default:     state_next = BRANCH;
        endcase
      end
      MEMADR: begin
        ALUSrcB    = 2'b01;
        ALUControl = ALU_ADD;
        state_next = is_load_or_link ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc     = 2'b01;
        state_next = MEMWB;
      end
      MEMWB: begin
        reg_we     = 1'b1;
        ResultSrc  = 2'b01;
        state_next = FETCH;
      end
      MEMWR: begin
        mem_we     = 1'b1;
        AdrSrc     = 2'b01;
        state_next = FETCH;
      end
      EXECR: begin
        ALUControl = alu_ctrl(cmd);
        state_next = ALUWB;
      end
      EXECI: begin
        ALUSrcB    = 2'b01;
        ImmSrc     = 1'b1;
        ALUControl = alu_ctrl(cmd);
        state_next = ALUWB;
      end
      ALUWB: begin
        reg_we     = (cmd != CMD_CMP);
        state_next = FETCH;
      end
      BRANCH: begin
        if (cond_ex) begin
          pc_we      = 1'b1;
          ALUSrcA    = 1'b1;
          ALUSrcB    = 2'b01;
          ALUControl = ALU_ADD;
          ResultSrc  = 2'b10;
          if (is_load_or_link) begin
            reg_we    = 1'b1;
            RegSrc[0] = 1'b1;
          end
        end
        state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

  // Enables are forced low for as long as reset is held
  assign PCWrite  = pc_we  & ~rst;
  assign MemWrite = mem_we & ~rst;
  assign IRWrite  = ir_we  & ~rst;
  assign RegWrite = reg_we & ~rst;
  assign state_o  = state;

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_cycle_controller
// Purpose  : Scoreboard bench for multi_cycle_controller with directed
//            instruction sequences and hand-derived per-cycle outputs.
// Revision : 1.0  initial release
// ============================================================================
module tb_multi_cycle_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] Instr = 16'h0000;
  logic [3:0]  ALUFlags = 4'b0000;
  logic        PCWrite, MemWrite, IRWrite, RegWrite, ImmSrc, ALUSrcA;
  logic [1:0]  AdrSrc, ALUSrcB, ResultSrc;
  logic [3:0]  ALUControl, state_o;
  logic [2:0]  RegSrc;

  int total = 0;
  int bad   = 0;

  // {state, PCW, MW, IRW, RW, ALUSrcA, ALUSrcB, AdrSrc, ALUControl, RegSrc, ResultSrc, ImmSrc}
  typedef logic [24:0] exp_t;
  exp_t  exp_q[$];
  string name_q[$];

  multi_cycle_controller dut (
    .clk(clk), .rst(rst), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA),
    .AdrSrc(AdrSrc), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .RegSrc(RegSrc), .ResultSrc(ResultSrc), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Monitor: DUT presents a control word every cycle; compare mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      exp_t  got;
      string nm;
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      got = {state_o, PCWrite, MemWrite, IRWrite, RegWrite, ALUSrcA, ALUSrcB,
             AdrSrc, ALUControl, RegSrc, ResultSrc, ImmSrc};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL %s: got=%h expected=%h", nm, got, e);
      end
    end
  end

  // Queue the expected word for the current cycle, then advance one clock
  task automatic cyc(input string nm, input logic [3:0] st,
                     input logic pcw, input logic mw, input logic irw, input logic rw,
                     input logic asa, input logic [1:0] asb, input logic [1:0] adr,
                     input logic [3:0] alc, input logic [2:0] rsrc,
                     input logic [1:0] res, input logic imm);
    exp_q.push_back({st, pcw, mw, irw, rw, asa, asb, adr, alc, rsrc, res, imm});
    name_q.push_back(nm);
    @(posedge clk); #1;
  endtask

  task automatic fetch_decode(input logic [15:0] ins);
    Instr = ins;
    cyc("fetch",  4'd0, 1,0,1,0, 1, 2'b10, 2'b00, 4'b0100, 3'b000, 2'b10, 0);
    cyc("decode", 4'd1, 0,0,0,0, 0, 2'b00, 2'b00, 4'b0000, 3'b000, 2'b00, 0);
  endtask

  task automatic br(input string nm, input logic [15:0] ins, input logic taken, input logic link);
    fetch_decode(ins);
    if (taken)
      cyc(nm, 4'd9, 1,0,0,link, 1, 2'b01, 2'b00, 4'b0100, {2'b00, link}, 2'b10, 0);
    else
      cyc(nm, 4'd9, 0,0,0,0, 0, 2'b00, 2'b00, 4'b0000, 3'b000, 2'b00, 0);
  endtask

  initial begin
    // Held in reset: FETCH selects, all enables gated off
    @(posedge clk); #1;
    cyc("reset_hold", 4'd0, 0,0,0,0, 1, 2'b10, 2'b00, 4'b0100, 3'b000, 2'b10, 0);
    rst = 1'b0;

    // Register-form ADD: 0x1104 -> EXECR, ALUWB writes
    fetch_decode(16'h1104);
    cyc("add_execr", 4'd6, 0,0,0,0, 0, 2'b00, 2'b00, 4'b0100, 3'b000, 2'b00, 0);
    cyc("add_aluwb", 4'd8, 0,0,0,1, 0, 2'b00, 2'b00, 4'b0000, 3'b000, 2'b00, 0);

    // 0x5104 has class bits 01, so it runs the immediate path
    fetch_decode(16'h5104);
    cyc("addi_execi", 4'd7, 0,0,0,0, 0, 2'b01, 2'b00, 4'b0100, 3'b000, 2'b00, 1);
    cyc("addi_aluwb", 4'd8, 0,0,0,1, 0, 2'b00, 2'b00, 4'b0000, 3'b000, 2'b00, 0);

    // LDR 0xA105
    fetch_decode(16'hA105);
    cyc("ldr_memadr", 4'd2, 0,0,0,0, 0, 2'b01, 2'b00, 4'b0100, 3'b000, 2'b00, 0);
    cyc("ldr_memrd",  4'd3, 0,0,0,0, 0, 2'b00, 2'b01, 4'b0000, 3'b000, 2'b00, 0);
    cyc("ldr_memwb",  4'd4, 0,0,0,1, 0, 2'b00, 2'b00, 4'b0000, 3'b000, 2'b01, 0);

    // STR 0x8105
    fetch_decode(16'h8105);
    cyc("str_memadr", 4'd2, 0,0,0,0, 0, 2'b01, 2'b00, 4'b0100, 3'b000, 2'b00, 0);
    cyc("str_memwr",  4'd5, 0,1,0,0, 0, 2'b00, 2'b01, 4'b0000, 3'b000, 2'b00, 0);

    // CMP 0x2000 with Z set: ALU op SUB, no register write, flags <- 0100
    fetch_decode(16'h2000);
    ALUFlags = 4'b0100;
    cyc("cmp_execr", 4'd6, 0,0,0,0, 0, 2'b00, 2'b00, 4'b0010, 3'b000, 2'b00, 0);
    ALUFlags = 4'b0000;  // must not be captured outside the EXEC edge
    cyc("cmp_aluwb", 4'd8, 0,0,0,0, 0, 2'b00, 2'b00, 4'b0000, 3'b000, 2'b00, 0);

    br("beq_taken",   16'hC000, 1, 0);
    br("bne_untaken", 16'hC100, 0, 0);
    br("bmi_untaken", 16'hC400, 0, 0);
    br("cond_1111",   16'hCF00, 0, 0);
    br("bl_al",       16'hEE00, 1, 1);

    // EOR immediate 0x7000 with flags 0000 clears Z
    fetch_decode(16'h7000);
    cyc("eori_execi", 4'd7, 0,0,0,0, 0, 2'b01, 2'b00, 4'b0001, 3'b000, 2'b00, 1);
    cyc("eori_aluwb", 4'd8, 0,0,0,1, 0, 2'b00, 2'b00, 4'b0000, 3'b000, 2'b00, 0);
    br("beq_untaken", 16'hC000, 0, 0);
    br("bne_taken",   16'hC100, 1, 0);

    // Reset pulsed in MEMWR: write must drop at once
    fetch_decode(16'h8105);
    cyc("str2_memadr", 4'd2, 0,0,0,0, 0, 2'b01, 2'b00, 4'b0100, 3'b000, 2'b00, 0);
    exp_q.push_back({4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 4'b0000, 3'b000, 2'b00, 1'b0});
    name_q.push_back("str2_memwr");
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    total++;
    if (MemWrite !== 1'b0) begin
      bad++;
      $display("FAIL abort_memwrite: got=%b expected=0", MemWrite);
    end
    total++;
    if (state_o !== 4'd0) begin
      bad++;
      $display("FAIL abort_state: got=%0d expected=0", state_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // First edge after release executes FETCH
    fetch_decode(16'hEE00);
    cyc("post_rst_bl", 4'd9, 1,0,0,1, 1, 2'b01, 2'b00, 4'b0100, 3'b001, 2'b10, 0);
    cyc("post_rst_fetch", 4'd0, 1,0,1,0, 1, 2'b10, 2'b00, 4'b0100, 3'b000, 2'b10, 0);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
